hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage ARM pipeline. Drives the stall, flush and

---
 rtl/hazard_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 102 ++++++++++
 tb/tb_hazard_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Pipeline hazard control bundle: register addresses, pipeline status in,
// stall/flush/forward controls and status out.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       Ra1D, Ra2D, Ra1E, Ra2E;
  logic [3:0]       WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic             BranchTakenE;
  logic             MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt;

  modport slave (
    input  Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
           MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, StallCnt
  );

  modport master (
    output Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
           MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, StallCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use stall, PC flushes,
// data-memory wait handling with timeout, and a saturating stall counter.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic      clk,
  input logic      reset_n,
  hazard_if.slave  hz
);
  localparam int TW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             ldr_stall, pc_pend, mem_stall, stall_d;

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic wr_m,
                                         input logic [3:0] wa_m, input logic wr_w,
                                         input logic [3:0] wa_w);
    if (wr_m && ra == wa_m)      return 2'b10;
    else if (wr_w && ra == wa_w) return 2'b01;
    else                         return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign ldr_stall = hz.MemtoRegE && hz.RegWriteE &&
                     (hz.Ra1D == hz.WA3E || hz.Ra2D == hz.WA3E);
  assign pc_pend   = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
  assign mem_stall = hz.MemReqM && !hz.MemReadyM && (state != ERR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (mem_stall) begin
        state_nxt = WAIT;
        cnt_nxt   = TW'(1);
      end
      WAIT: begin
        if (hz.MemReadyM || !hz.MemReqM) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == TW'(MEM_TIMEOUT - 1)) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs: ERR freezes the whole pipeline and disables forwarding.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b1;
    stall_d      = 1'b1;
    hz.StallE    = 1'b1;
    hz.StallM    = 1'b1;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    if (state != ERR) begin
      hz.ForwardAE = fwd_sel(hz.Ra1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
      hz.ForwardBE = fwd_sel(hz.Ra2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
      hz.StallF    = ldr_stall | pc_pend | mem_stall;
      stall_d      = ldr_stall | mem_stall;
      hz.StallE    = mem_stall;
      hz.StallM    = mem_stall;
      hz.FlushD    = (pc_pend | hz.PCSrcW | hz.BranchTakenE) & ~mem_stall;
      hz.FlushE    = (ldr_stall | hz.BranchTakenE) & ~mem_stall;
      hz.FlushW    = mem_stall;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     stall_cnt <= '0;
    else if (stall_d) stall_cnt <= sat_inc(stall_cnt);
  end

  assign hz.StallD   = stall_d;
  assign hz.MemErr   = (state == ERR);
  assign hz.StallCnt = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: rule-level reference model compared every cycle, plus
// directed scenarios with literal expected values.
module tb_hazard_ctrl;
  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int CNTMX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_if #(.CNT_W(CW)) hz ();
  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .hz(hz.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: number of consecutive memory-wait cycles, error flag, stall count.
  int m_wait = 0;
  bit m_err  = 0;
  int m_scnt = 0;

  function automatic int m_fwd(input logic [3:0] ra);
    if (hz.RegWriteM && ra == hz.WA3M) return 2;
    if (hz.RegWriteW && ra == hz.WA3W) return 1;
    return 0;
  endfunction

  function automatic bit m_ld();
    return hz.MemtoRegE && hz.RegWriteE && (hz.Ra1D == hz.WA3E || hz.Ra2D == hz.WA3E);
  endfunction

  function automatic bit m_ms();
    return !m_err && hz.MemReqM && !hz.MemReadyM;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_wait = 0; m_err = 0; m_scnt = 0;
    end else begin
      if ((m_err || m_ld() || m_ms()) && m_scnt < CNTMX) m_scnt++;
      if (!m_err) begin
        if (m_ms()) begin
          m_wait++;
          if (m_wait >= TO) m_err = 1;
        end else m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit ms, ld, pp;
    ms = m_ms(); ld = m_ld();
    pp = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
    if (m_err) begin
      chk("m.ForwardAE", hz.ForwardAE, 0);
      chk("m.ForwardBE", hz.ForwardBE, 0);
      chk("m.Stalls", {hz.StallF, hz.StallD, hz.StallE, hz.StallM}, 4'hF);
      chk("m.Flushes", {hz.FlushD, hz.FlushE, hz.FlushW}, 0);
    end else begin
      chk("m.ForwardAE", hz.ForwardAE, m_fwd(hz.Ra1E));
      chk("m.ForwardBE", hz.ForwardBE, m_fwd(hz.Ra2E));
      chk("m.StallF", hz.StallF, int'(ld | pp | ms));
      chk("m.StallD", hz.StallD, int'(ld | ms));
      chk("m.StallE", hz.StallE, int'(ms));
      chk("m.StallM", hz.StallM, int'(ms));
      chk("m.FlushD", hz.FlushD, int'((pp | hz.PCSrcW | hz.BranchTakenE) & !ms));
      chk("m.FlushE", hz.FlushE, int'((ld | hz.BranchTakenE) & !ms));
      chk("m.FlushW", hz.FlushW, int'(ms));
    end
    chk("m.MemErr", hz.MemErr, int'(m_err));
    chk("m.StallCnt", hz.StallCnt, m_scnt);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    hz.Ra1D = 4'd0; hz.Ra2D = 4'd0; hz.Ra1E = 4'd0; hz.Ra2E = 4'd0;
    hz.WA3E = 4'd14; hz.WA3M = 4'd14; hz.WA3W = 4'd14;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0; hz.MemtoRegE = 0;
    hz.PCSrcD = 0; hz.PCSrcE = 0; hz.PCSrcM = 0; hz.PCSrcW = 0; hz.BranchTakenE = 0;
    hz.MemReqM = 0; hz.MemReadyM = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    step();
    chk("rst.StallCnt", hz.StallCnt, 0);
    chk("rst.MemErr", hz.MemErr, 0);
    chk("rst.StallF", hz.StallF, 0);
    do_reset();

    // Forwarding: M wins over W, then W alone, then no match.
    step();
    hz.RegWriteM = 1; hz.WA3M = 4'd3; hz.RegWriteW = 1; hz.WA3W = 4'd3;
    hz.Ra1E = 4'd3; hz.Ra2E = 4'd3; #1;
    chk("t1.FwdA_M", hz.ForwardAE, 2);
    chk("t1.FwdB_M", hz.ForwardBE, 2);
    step(); hz.RegWriteM = 0; #1;
    chk("t1.FwdA_W", hz.ForwardAE, 1);
    step(); hz.Ra1E = 4'd7; #1;
    chk("t1.FwdA_none", hz.ForwardAE, 0);
    chk("t1.FwdB_W", hz.ForwardBE, 1);
    step(); clear_inputs();

    // Load-use: one stall cycle, then the load has moved on.
    step();
    hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.WA3E = 4'd5; hz.Ra2D = 4'd5; #1;
    chk("t2.ctl", {hz.StallF, hz.StallD, hz.StallE, hz.FlushE}, 4'b1101);
    step(); hz.MemtoRegE = 0; hz.RegWriteE = 0; #1;
    chk("t2.after", {hz.StallF, hz.StallD, hz.FlushE}, 0);

    // Branch taken, then a PC write travelling D->E->M->W.
    step(); hz.BranchTakenE = 1; #1;
    chk("t3.br", {hz.FlushD, hz.FlushE, hz.StallF}, 3'b110);
    step(); hz.BranchTakenE = 0; hz.PCSrcD = 1; #1;
    chk("t3.pcD", {hz.StallF, hz.FlushD, hz.FlushE}, 3'b110);
    step(); hz.PCSrcD = 0; hz.PCSrcE = 1; #1;
    chk("t3.pcE", {hz.StallF, hz.FlushD}, 2'b11);
    step(); hz.PCSrcE = 0; hz.PCSrcM = 1; #1;
    chk("t3.pcM", {hz.StallF, hz.FlushD}, 2'b11);
    step(); hz.PCSrcM = 0; hz.PCSrcW = 1; #1;
    chk("t3.pcW", {hz.StallF, hz.FlushD}, 2'b01);
    step(); clear_inputs();

    // Memory wait of three cycles with a branch pending underneath.
    do_reset();
    step(); hz.MemReqM = 1; hz.MemReadyM = 0; hz.BranchTakenE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4.stall", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}, 5'h1F);
      chk("t4.noflush", {hz.FlushD, hz.FlushE}, 0);
      step();
    end
    hz.MemReadyM = 1; #1;
    chk("t4.ready", {hz.StallF, hz.StallM, hz.FlushW, hz.FlushD}, 4'b0001);
    step(); clear_inputs(); #1;
    chk("t4.StallCnt", hz.StallCnt, 3);
    chk("t4.MemErr", hz.MemErr, 0);

    // Timeout into ERR, stalls held, counter saturates, reset clears.
    do_reset();
    step(); hz.MemReqM = 1; hz.MemReadyM = 0; #1;
    chk("t5.stallF", hz.StallF, 1);
    step(); step(); step(); #1;
    chk("t5.noerr3", hz.MemErr, 0);
    step(); #1;
    chk("t5.err4", hz.MemErr, 1);
    clear_inputs(); hz.RegWriteM = 1; hz.WA3M = 4'd2; hz.Ra1E = 4'd2; #1;
    chk("t5.held", {hz.StallF, hz.StallD, hz.StallE, hz.StallM}, 4'hF);
    chk("t5.nofwd", hz.ForwardAE, 0);
    for (int i = 0; i < 12; i++) step();
    chk("t6.sat", hz.StallCnt, CNTMX);
    step(); #1;
    chk("t6.sat2", hz.StallCnt, CNTMX);
    clear_inputs(); reset_n = 1'b0; #1;
    chk("t5.rst.MemErr", hz.MemErr, 0);
    chk("t5.rst.stall", {hz.StallF, hz.StallD, hz.StallE, hz.StallM}, 0);
    chk("t5.rst.StallCnt", hz.StallCnt, 0);
    step(); reset_n = 1'b1;

    // Reset in the middle of a wait, then a fresh wait must not error early.
    step(); hz.MemReqM = 1; hz.MemReadyM = 0;
    step(); step(); #1;
    chk("t6.preRst", hz.StallCnt, 2);
    hz.MemReqM = 0; reset_n = 1'b0; #1;
    chk("t6.rst.StallCnt", hz.StallCnt, 0);
    chk("t6.rst.stall", {hz.StallF, hz.StallM}, 0);
    step(); reset_n = 1'b1;
    step(); hz.MemReqM = 1;
    step(); step(); step(); #1;
    chk("t6.fresh.MemErr", hz.MemErr, 0);
    hz.MemReadyM = 1;
    step(); clear_inputs();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
